// File: rtl/pcie_bar0_responder.sv
// pcie_bar0_responder: Avalon-MM slave behind the PCIe hard IP BAR0 receive
// master. It backs the BAR with a 2^ADDR_W x 128-bit on-chip window. It takes
// single and burst writes with byte enables and returns pipelined burst reads.
// The top word of the window also acts as a doorbell that drives rxm_irq[0].
module pcie_bar0_responder #(
  parameter int unsigned  ADDR_W   = 8,
  parameter logic [127:0] OOR_DATA = {4{32'hDEADBEEF}}
) (
  input  logic         coreclkout_hip,
  input  logic         app_nreset_status,
  input  logic [63:0]  rxm_bar0_address_i,
  input  logic [15:0]  rxm_bar0_byteenable_i,
  input  logic [127:0] rxm_bar0_writedata_i,
  input  logic         rxm_bar0_read_i,
  input  logic         rxm_bar0_write_i,
  input  logic [5:0]   rxm_bar0_burstcount_i,
  output logic [127:0] rxm_bar0_readdata_o,
  output logic         rxm_bar0_readdatavalid_o,
  output logic         rxm_bar0_waitrequest_o,
  output logic         irq_o,
  output logic [15:0]  err_count_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  localparam int unsigned       DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] TOP_IDX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [127:0]      mem_r [DEPTH];

  state_t            state_r;
  logic [5:0]        remaining_r;
  logic [ADDR_W-1:0] widx_r;
  logic              oor_r;
  logic              waitrequest_r;
  logic [127:0]      readdata_r;
  logic              rdvalid_r;
  logic              irq_r;
  logic [15:0]       err_count_r;

  logic [ADDR_W-1:0] cmd_widx_s;
  logic              cmd_oor_s;
  logic [5:0]        cmd_len_s;
  logic              idle_ready_s;
  logic              accept_s;
  logic              wr_beat_s;
  logic [ADDR_W-1:0] wr_idx_s;
  logic              wr_oor_s;
  logic              mem_we_s;
  logic              doorbell_s;
  logic              unused_s;

  // Low address bits only select bytes inside a 128-bit word and are ignored.
  assign unused_s     = ^rxm_bar0_address_i[3:0];

  assign cmd_widx_s   = rxm_bar0_address_i[ADDR_W+3:4];
  assign cmd_oor_s    = |rxm_bar0_address_i[63:ADDR_W+4];
  assign cmd_len_s    = (rxm_bar0_burstcount_i == 6'd0) ? 6'd1 : rxm_bar0_burstcount_i;
  assign idle_ready_s = (state_r == IDLE) && !waitrequest_r;
  assign accept_s     = idle_ready_s && (rxm_bar0_write_i || rxm_bar0_read_i);
  assign mem_we_s     = wr_beat_s && !wr_oor_s;
  assign doorbell_s   = mem_we_s && (wr_idx_s == TOP_IDX) && rxm_bar0_byteenable_i[0];

  // Select which word a write beat targets: the command address on the first
  // beat, the running burst index afterwards.
  always_comb begin
    wr_beat_s = 1'b0;
    wr_idx_s  = widx_r;
    wr_oor_s  = oor_r;
    case (state_r)
      IDLE: begin
        wr_beat_s = idle_ready_s && rxm_bar0_write_i;
        wr_idx_s  = cmd_widx_s;
        wr_oor_s  = cmd_oor_s;
      end
      WR_BURST: begin
        wr_beat_s = rxm_bar0_write_i;
        wr_idx_s  = widx_r;
        wr_oor_s  = oor_r;
      end
      default: begin
        wr_beat_s = 1'b0;
        wr_idx_s  = widx_r;
        wr_oor_s  = oor_r;
      end
    endcase
  end

  // Window storage: byte-masked writes, contents survive reset.
  always_ff @(posedge coreclkout_hip) begin
    if (mem_we_s) begin
      for (int b = 0; b < 16; b++) begin
        if (rxm_bar0_byteenable_i[b]) begin
          mem_r[wr_idx_s][b*8 +: 8] <= rxm_bar0_writedata_i[b*8 +: 8];
        end
      end
    end
  end

  // Command FSM: accepts commands, walks burst indices and drives waitrequest.
  always_ff @(posedge coreclkout_hip or negedge app_nreset_status) begin
    if (!app_nreset_status) begin
      state_r       <= IDLE;
      remaining_r   <= 6'd0;
      widx_r        <= {ADDR_W{1'b0}};
      oor_r         <= 1'b0;
      waitrequest_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          waitrequest_r <= 1'b0;
          if (idle_ready_s && rxm_bar0_write_i) begin
            // A write wins over a simultaneous read; the read is dropped.
            widx_r      <= cmd_widx_s + IDX_ONE;
            oor_r       <= cmd_oor_s;
            remaining_r <= cmd_len_s - 6'd1;
            state_r     <= (cmd_len_s == 6'd1) ? IDLE : WR_BURST;
          end else if (idle_ready_s && rxm_bar0_read_i) begin
            widx_r        <= cmd_widx_s;
            oor_r         <= cmd_oor_s;
            remaining_r   <= cmd_len_s;
            state_r       <= RD_BURST;
            waitrequest_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        WR_BURST: begin
          waitrequest_r <= 1'b0;
          if (rxm_bar0_write_i) begin
            widx_r      <= widx_r + IDX_ONE;
            remaining_r <= remaining_r - 6'd1;
            state_r     <= (remaining_r == 6'd1) ? IDLE : WR_BURST;
          end else begin
            state_r <= WR_BURST;
          end
        end
        RD_BURST: begin
          widx_r      <= widx_r + IDX_ONE;
          remaining_r <= remaining_r - 6'd1;
          if (remaining_r == 6'd1) begin
            state_r       <= IDLE;
            waitrequest_r <= 1'b0;
          end else begin
            state_r       <= RD_BURST;
            waitrequest_r <= 1'b1;
          end
        end
        default: begin
          state_r       <= IDLE;
          waitrequest_r <= 1'b0;
        end
      endcase
    end
  end

  // Read pipeline: one word per RD_BURST cycle, data held between beats.
  always_ff @(posedge coreclkout_hip or negedge app_nreset_status) begin
    if (!app_nreset_status) begin
      readdata_r <= 128'd0;
      rdvalid_r  <= 1'b0;
    end else begin
      rdvalid_r <= (state_r == RD_BURST);
      if (state_r == RD_BURST) begin
        readdata_r <= oor_r ? OOR_DATA : mem_r[widx_r];
      end else begin
        readdata_r <= readdata_r;
      end
    end
  end

  // Doorbell flop loaded from bit 0 of writes to the top word.
  always_ff @(posedge coreclkout_hip or negedge app_nreset_status) begin
    if (!app_nreset_status) begin
      irq_r <= 1'b0;
    end else if (doorbell_s) begin
      irq_r <= rxm_bar0_writedata_i[0];
    end else begin
      irq_r <= irq_r;
    end
  end

  // Saturating count of out-of-range bursts, bumped at command acceptance.
  always_ff @(posedge coreclkout_hip or negedge app_nreset_status) begin
    if (!app_nreset_status) begin
      err_count_r <= 16'd0;
    end else if (accept_s && cmd_oor_s && (err_count_r != 16'hFFFF)) begin
      err_count_r <= err_count_r + 16'd1;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign rxm_bar0_readdata_o      = readdata_r;
  assign rxm_bar0_readdatavalid_o = rdvalid_r;
  assign rxm_bar0_waitrequest_o   = waitrequest_r;
  assign irq_o                    = irq_r;
  assign err_count_o              = err_count_r;

endmodule

// File: tb/tb_pcie_bar0_responder.sv
// Self-checking bench for pcie_bar0_responder: a vector table of single-beat
// writes/reads, then hand-written burst, OOR, doorbell and reset sequences.
// Read data goes through a scoreboard queue popped on readdatavalid.
module tb_pcie_bar0_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  address;
  logic [15:0]  byteenable;
  logic [127:0] writedata;
  logic         read;
  logic         write;
  logic [5:0]   burstcount;
  logic [127:0] readdata;
  logic         readdatavalid;
  logic         waitrequest;
  logic         irq;
  logic [15:0]  err_count;

  localparam logic [127:0] OOR_WORD = {4{32'hDEADBEEF}};
  localparam logic [63:0]  OOR_ADDR = 64'h0000_0001_0000_0000;

  pcie_bar0_responder dut (
    .coreclkout_hip           (clk),
    .app_nreset_status        (rst_n),
    .rxm_bar0_address_i       (address),
    .rxm_bar0_byteenable_i    (byteenable),
    .rxm_bar0_writedata_i     (writedata),
    .rxm_bar0_read_i          (read),
    .rxm_bar0_write_i         (write),
    .rxm_bar0_burstcount_i    (burstcount),
    .rxm_bar0_readdata_o      (readdata),
    .rxm_bar0_readdatavalid_o (readdatavalid),
    .rxm_bar0_waitrequest_o   (waitrequest),
    .irq_o                    (irq),
    .err_count_o              (err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rv_cnt  = 0;
  logic [127:0] exp_q [$];

  typedef struct {
    bit           wr;
    logic [63:0]  addr;
    logic [15:0]  be;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [127:0] pat(input int i);
    pat = {64'hC0DE_C0DE_0000_0000, 32'h0, 24'(i), 8'h00};
  endfunction

  // Scoreboard: every beat is compared against the oldest expected word.
  always @(negedge clk) begin
    logic [127:0] e;
    if (rst_n && readdatavalid) begin
      rv_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got readdatavalid=1 data %h, required no beat", readdata);
      end else begin
        e = exp_q.pop_front();
        check("read_beat", readdata, e);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write      = 1'b0;
    read       = 1'b0;
    address    = 64'd0;
    byteenable = 16'd0;
    writedata  = 128'd0;
    burstcount = 6'd0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (waitrequest && k < 50) begin
      next_cycle();
      k++;
    end
    check("wait_ready", {127'd0, waitrequest}, 128'd0);
  endtask

  task automatic wr_cmd(input logic [63:0] a, input logic [15:0] be, input logic [127:0] d,
                        input logic [5:0] n);
    wait_ready();
    write      = 1'b1;
    address    = a;
    byteenable = be;
    writedata  = d;
    burstcount = n;
    next_cycle();
    idle_inputs();
  endtask

  task automatic wr_beat(input logic [15:0] be, input logic [127:0] d);
    write      = 1'b1;
    address    = 64'hFFFF_FFFF_FFFF_FFF0;
    byteenable = be;
    writedata  = d;
    burstcount = 6'd3;
    next_cycle();
    idle_inputs();
  endtask

  task automatic rd_cmd(input logic [63:0] a, input logic [5:0] n);
    wait_ready();
    read       = 1'b1;
    address    = a;
    burstcount = n;
    next_cycle();
    idle_inputs();
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      next_cycle();
      k++;
    end
    check("drain_pending", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
  endtask

  // Issue a read and record readdatavalid / waitrequest for cycles T+1..T+15.
  task automatic read_profile(input logic [63:0] a, input logic [5:0] n,
                              output logic [15:0] rv_bits, output logic [15:0] wq_bits);
    rv_bits = 16'd0;
    wq_bits = 16'd0;
    wait_ready();
    read       = 1'b1;
    address    = a;
    burstcount = n;
    next_cycle();
    idle_inputs();
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      rv_bits[c] = readdatavalid;
      wq_bits[c] = waitrequest;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rv_bits;
    logic [15:0] wq_bits;
    logic [15:0] rv_exp;
    logic [15:0] wq_exp;
    int          k;

    vecs[0] = '{1'b1, 64'h40, 16'hFFFF, 128'h00112233_44556677_8899AABB_CCDDEEFF, 128'd0};
    vecs[1] = '{1'b0, 64'h40, 16'h0000, 128'd0, 128'h00112233_44556677_8899AABB_CCDDEEFF};
    vecs[2] = '{1'b1, 64'h30, 16'hFFFF, {128{1'b1}}, 128'd0};
    vecs[3] = '{1'b1, 64'h30, 16'h00F0, 128'd0, 128'd0};
    vecs[4] = '{1'b0, 64'h3C, 16'h0000, 128'd0, 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF};
    vecs[5] = '{1'b1, 64'h50, 16'hFFFF, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 128'd0};
    vecs[6] = '{1'b1, 64'h5F, 16'h8001, {16{8'hAA}}, 128'd0};
    vecs[7] = '{1'b0, 64'h57, 16'h0000, 128'd0, 128'hAA234567_89ABCDEF_FEDCBA98_765432AA};

    // Reset state.
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_waitrequest", {127'd0, waitrequest}, 128'd1);
    check("rst_rdvalid", {127'd0, readdatavalid}, 128'd0);
    check("rst_readdata", readdata, 128'd0);
    check("rst_irq", {127'd0, irq}, 128'd0);
    check("rst_err_count", {112'd0, err_count}, 128'd0);
    rst_n = 1'b1;
    #1;
    check("wreq_before_edge", {127'd0, waitrequest}, 128'd1);
    next_cycle();
    check("wreq_after_edge", {127'd0, waitrequest}, 128'd0);

    // Vector table: single-beat writes and reads.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) begin
        wr_cmd(vecs[i].addr, vecs[i].be, vecs[i].data, 6'd1);
      end else begin
        exp_q.push_back(vecs[i].exp);
        rd_cmd(vecs[i].addr, 6'd1);
        drain();
      end
    end

    // Single-read timing at 0x40.
    exp_q.push_back(vecs[0].data);
    read_profile(64'h40, 6'd1, rv_bits, wq_bits);
    check("single_rv_profile", {112'd0, rv_bits}, {112'd0, 16'h0004});
    check("single_wq_profile", {112'd0, wq_bits}, {112'd0, 16'h0002});
    check("readdata_hold", readdata, vecs[0].data);
    drain();

    // Wrapping 8-beat write with a gap, then 8-beat read.
    wr_cmd(64'hFC0, 16'hFFFF, pat(0), 6'd8);
    next_cycle();
    for (int i = 1; i < 8; i++) wr_beat(16'hFFFF, pat(i));
    check("wrap_irq_low", {127'd0, irq}, 128'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back(pat(i));
    read_profile(64'hFC0, 6'd8, rv_bits, wq_bits);
    rv_exp = 16'h03FC;
    wq_exp = 16'h01FE;
    check("wrap_rv_profile", {112'd0, rv_bits}, {112'd0, rv_exp});
    check("wrap_wq_profile", {112'd0, wq_bits}, {112'd0, wq_exp});
    drain();

    // Out-of-range write and read.
    wr_cmd(OOR_ADDR, 16'hFFFF, {128{1'b1}}, 6'd4);
    for (int i = 1; i < 4; i++) wr_beat(16'hFFFF, {128{1'b1}});
    for (int i = 0; i < 4; i++) exp_q.push_back(OOR_WORD);
    rd_cmd(OOR_ADDR, 6'd4);
    drain();
    for (int i = 4; i < 8; i++) exp_q.push_back(pat(i));
    rd_cmd(64'h0, 6'd4);
    drain();
    check("oor_err_count", {112'd0, err_count}, 128'd2);

    // Saturation: 65533 more single-beat OOR writes, then one more burst.
    wait_ready();
    write      = 1'b1;
    address    = OOR_ADDR;
    byteenable = 16'hFFFF;
    writedata  = 128'd0;
    burstcount = 6'd1;
    repeat (65533) next_cycle();
    idle_inputs();
    check("err_count_full", {112'd0, err_count}, 128'h0000_FFFF);
    exp_q.push_back(OOR_WORD);
    rd_cmd(OOR_ADDR, 6'd1);
    drain();
    check("err_count_saturated", {112'd0, err_count}, 128'h0000_FFFF);

    // Doorbell set, then write/read collision clears it.
    check("irq_before", {127'd0, irq}, 128'd0);
    wr_cmd(64'hFF0, 16'h0001, 128'd1, 6'd1);
    check("irq_rise", {127'd0, irq}, 128'd1);
    rv_cnt = 0;
    wait_ready();
    read       = 1'b1;
    write      = 1'b1;
    address    = 64'hFF0;
    byteenable = 16'hFFFF;
    writedata  = 128'd0;
    burstcount = 6'd1;
    next_cycle();
    idle_inputs();
    check("irq_fall", {127'd0, irq}, 128'd0);
    check("collision_no_stall", {127'd0, waitrequest}, 128'd0);
    repeat (5) next_cycle();
    check("collision_no_beat", 128'(rv_cnt), 128'd0);
    exp_q.push_back(128'd0);
    rd_cmd(64'hFF0, 6'd1);
    drain();

    // Reset in the middle of a 16-beat read.
    rv_cnt = 0;
    for (int i = 0; i < 3; i++) exp_q.push_back(pat(i));
    rd_cmd(64'hFC0, 6'd16);
    k = 0;
    while (rv_cnt < 3 && k < 20) begin
      next_cycle();
      k++;
    end
    check("midread_beats_seen", 128'(rv_cnt), 128'd3);
    rst_n = 1'b0;
    #1;
    check("midrst_waitrequest", {127'd0, waitrequest}, 128'd1);
    check("midrst_rdvalid", {127'd0, readdatavalid}, 128'd0);
    check("midrst_readdata", readdata, 128'd0);
    check("midrst_irq", {127'd0, irq}, 128'd0);
    check("midrst_err_count", {112'd0, err_count}, 128'd0);
    exp_q.delete();
    repeat (3) next_cycle();
    rst_n = 1'b1;
    #1;
    check("rel_wreq_before_edge", {127'd0, waitrequest}, 128'd1);
    next_cycle();
    check("rel_wreq_after_edge", {127'd0, waitrequest}, 128'd0);
    repeat (20) next_cycle();
    check("midrst_no_more_beats", 128'(rv_cnt), 128'd3);

    // Memory contents survive reset.
    exp_q.push_back(pat(4));
    rd_cmd(64'h0, 6'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
